request_arb_unit: RTL and testbench

//  Successor to the single-channel request unit. Sits between the CPU control path
//  and the memory controller. Drives one instruction-fetch request and NCH data

---
 rtl/request_arb_unit_if.sv | 35 +++
 rtl/request_arb_unit.sv | 111 +++++++++++
 tb/tb_request_arb_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/request_arb_unit_if.sv
// Bus bundle between the CPU control path and the request arbiter: fetch/data
// request inputs, memory-side request outputs, status flags and FSM state.
interface request_arb_unit_if #(
    parameter int NCH = 2
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    // Handshake: a data requester holds dREN[c]/dWEN[c] from the ihit that captures
    // it until dhit is seen while dgrant[c]=1; dropping both early ends the grant.
    logic             iREN;
    logic [NCH-1:0]   dREN;
    logic [NCH-1:0]   dWEN;
    logic             ihit;
    logic             dhit;
    logic             halt;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic [NCH-1:0]   dgrant;
    logic [SEL_W-1:0] dsel;
    logic             pc_wait;
    logic             halt_out;
    logic             dtimeout;
    logic [1:0]       dbg_state;

    modport master (
        output iREN, dREN, dWEN, ihit, dhit, halt,
        input  imemREN, dmemREN, dmemWEN, dgrant, dsel, pc_wait, halt_out, dtimeout, dbg_state
    );

    modport slave (
        input  iREN, dREN, dWEN, ihit, dhit, halt,
        output imemREN, dmemREN, dmemWEN, dgrant, dsel, pc_wait, halt_out, dtimeout, dbg_state
    );
endinterface

// File: rtl/request_arb_unit.sv
// Instruction-fetch plus NCH-channel round-robin data request unit with PC stall,
// halt drain and a per-grant watchdog that aborts stuck data requests.
module request_arb_unit #(
    parameter int NCH     = 2,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input logic               CLK,
    input logic               RST,
    request_arb_unit_if.slave bus
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DREQ, S_HALTING, S_HALTED} state_t;

    state_t           r_state, w_state_nxt;
    logic [NCH-1:0]   r_pending, w_pending_nxt, w_set;
    logic [SEL_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [SEL_W-1:0] r_gidx, w_gidx_nxt, w_pick, w_k;
    logic             r_gvld, w_gvld_nxt, w_pick_vld;
    logic [TMO_W-1:0] r_wdog, w_wdog_nxt;
    logic             r_halt, r_dtimeout, w_dtimeout_nxt;
    logic             w_done, w_abort, w_release;

    // First pending channel at or after the round-robin pointer, wrapping.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_k        = '0;
        for (int i = 0; i < NCH; i++) begin
            w_k = SEL_W'((int'(r_rr_ptr) + i) % NCH);
            if (!w_pick_vld && r_pending[w_k]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_k;
            end
        end
    end

    always_comb begin
        w_set     = bus.ihit ? (bus.dREN | bus.dWEN) : '0;
        // A requester that withdraws both strobes mid-grant counts as finished.
        w_done    = r_gvld & (bus.dhit | ~(bus.dREN[r_gidx] | bus.dWEN[r_gidx]));
        w_abort   = r_gvld & ~w_done & (r_wdog == TMO_W'(TMO_MAX - 1));
        w_release = w_done | w_abort;

        w_pending_nxt = r_pending | w_set;
        if (w_release) w_pending_nxt[r_gidx] = 1'b0;

        w_gvld_nxt     = r_gvld;
        w_gidx_nxt     = r_gidx;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_wdog_nxt     = r_wdog;
        w_dtimeout_nxt = r_dtimeout;
        if (r_gvld) begin
            if (w_release) begin
                w_gvld_nxt     = 1'b0;
                w_wdog_nxt     = '0;
                w_rr_ptr_nxt   = (r_gidx == SEL_W'(NCH - 1)) ? '0 : r_gidx + 1'b1;
                w_dtimeout_nxt = r_dtimeout | w_abort;
            end else begin
                w_wdog_nxt = r_wdog + 1'b1;
            end
        end else if (w_pick_vld && (r_state != S_HALTED)) begin
            w_gvld_nxt = 1'b1;
            w_gidx_nxt = w_pick;
            w_wdog_nxt = '0;
        end

        w_state_nxt = r_state;
        if (r_state != S_HALTED) begin
            if (r_halt) begin
                w_state_nxt = (r_gvld || (|r_pending)) ? S_HALTING : S_HALTED;
            end else begin
                w_state_nxt = w_gvld_nxt ? S_DREQ : S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_rr_ptr   <= '0;
            r_gidx     <= '0;
            r_gvld     <= 1'b0;
            r_wdog     <= '0;
            r_halt     <= 1'b0;
            r_dtimeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_gidx     <= w_gidx_nxt;
            r_gvld     <= w_gvld_nxt;
            r_wdog     <= w_wdog_nxt;
            r_halt     <= r_halt | bus.halt;
            r_dtimeout <= w_dtimeout_nxt;
        end
    end

    // Data owns the memory port whenever a grant is live, so fetch only issues in IDLE.
    assign bus.imemREN   = (r_state == S_IDLE) & bus.iREN & ~r_halt;
    assign bus.dgrant    = r_gvld ? (NCH'(1) << r_gidx) : '0;
    assign bus.dsel      = r_gvld ? r_gidx : '0;
    assign bus.dmemWEN   = r_gvld & bus.dWEN[r_gidx];
    assign bus.dmemREN   = r_gvld & bus.dREN[r_gidx] & ~bus.dWEN[r_gidx];
    assign bus.pc_wait   = (|r_pending) | (r_state == S_DREQ) | (r_state == S_HALTING);
    assign bus.halt_out  = (r_state == S_HALTED);
    assign bus.dtimeout  = r_dtimeout;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_request_arb_unit.sv
// Directed bench for request_arb_unit: cycle-level behavioural model checked every
// cycle, plus literal expectations for reset, round-robin, conflict, watchdog, halt.
module tb_request_arb_unit;
    localparam int NCH     = 2;
    localparam int TMO_W   = 8;
    localparam int TMO_MAX = 200;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] exp_q[$];

    request_arb_unit_if #(.NCH(NCH)) bus ();

    request_arb_unit #(.NCH(NCH), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

    // ---------------- behavioural model ----------------
    int m_pend[NCH];
    int m_gch, m_rr, m_age;
    bit m_halt, m_draining, m_halted, m_tmo, m_ok;
    int t_np[NCH];
    int t_g, t_rr, t_age;
    bit t_done, t_abt, t_dr, t_hd, t_tmo, t_any;

    function automatic bit any_pend();
        for (int c = 0; c < NCH; c++) if (m_pend[c] != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < NCH; c++) m_pend[c] <= 0;
            m_gch <= -1; m_rr <= 0; m_age <= 0;
            m_halt <= 1'b0; m_draining <= 1'b0; m_halted <= 1'b0; m_tmo <= 1'b0;
            m_ok <= 1'b1;
        end else if (m_ok) begin
            t_g = m_gch; t_rr = m_rr; t_age = m_age;
            t_dr = m_draining; t_hd = m_halted; t_tmo = m_tmo;
            t_any = any_pend();
            t_done = 1'b0; t_abt = 1'b0;
            if (t_g >= 0) begin
                t_done = bus.dhit || !(bus.dREN[t_g] || bus.dWEN[t_g]);
                t_abt  = !t_done && (t_age == TMO_MAX - 1);
            end
            for (int c = 0; c < NCH; c++)
                t_np[c] = (m_pend[c] != 0 || (bus.ihit && (bus.dREN[c] || bus.dWEN[c]))) ? 1 : 0;
            if (t_done || t_abt) t_np[t_g] = 0;
            if (!m_halted && m_halt) begin
                if (t_g >= 0 || t_any) t_dr = 1'b1;
                else begin t_hd = 1'b1; t_dr = 1'b0; end
            end
            if (t_g >= 0) begin
                if (t_done || t_abt) begin
                    t_rr = (t_g + 1) % NCH; t_g = -1; t_age = 0; t_tmo = t_tmo | t_abt;
                end else begin
                    t_age = t_age + 1;
                end
            end else if (!m_halted && t_any) begin
                for (int i = 0; i < NCH; i++)
                    if (t_g < 0 && m_pend[(m_rr + i) % NCH] != 0) t_g = (m_rr + i) % NCH;
                t_age = 0;
            end
            for (int c = 0; c < NCH; c++) m_pend[c] <= t_np[c];
            m_gch <= t_g; m_rr <= t_rr; m_age <= t_age;
            m_halt <= m_halt | bus.halt;
            m_draining <= t_dr; m_halted <= t_hd; m_tmo <= t_tmo;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (m_ok) begin
            check("m_imemREN", int'(bus.imemREN), (bus.iREN && !m_halt && m_gch < 0) ? 1 : 0);
            check("m_dgrant", int'(bus.dgrant), (m_gch >= 0) ? (1 << m_gch) : 0);
            check("m_dsel", int'(bus.dsel), (m_gch >= 0) ? m_gch : 0);
            check("m_dmemWEN", int'(bus.dmemWEN), (m_gch >= 0 && bus.dWEN[m_gch]) ? 1 : 0);
            check("m_dmemREN", int'(bus.dmemREN),
                  (m_gch >= 0 && bus.dREN[m_gch] && !bus.dWEN[m_gch]) ? 1 : 0);
            check("m_pc_wait", int'(bus.pc_wait), (any_pend() || m_gch >= 0 || m_draining) ? 1 : 0);
            check("m_halt_out", int'(bus.halt_out), m_halted ? 1 : 0);
            check("m_dtimeout", int'(bus.dtimeout), m_tmo ? 1 : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic capture(input logic [NCH-1:0] ren, input logic [NCH-1:0] wen, input bit hlt);
        bus.dREN = ren; bus.dWEN = wen; bus.ihit = 1'b1; bus.halt = hlt;
        tick();
        bus.ihit = 1'b0; bus.halt = 1'b0;
    endtask

    task automatic wait_grant(input string name, output bit ok);
        int n;
        n = 0;
        while (bus.dgrant == '0 && n < 16) begin tick(); n++; end
        ok = (bus.dgrant != '0);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got no grant expected grant within 16 cycles", name);
        end
    endtask

    task automatic serve(input int lat);
        bit ok;
        int exp_ch;
        wait_grant("serve_wait", ok);
        exp_ch = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
        check("grant_order", ok ? int'(bus.dsel) : -1, exp_ch);
        if (ok) begin
            if (lat > 1) tick(lat - 1);
            bus.dhit = 1'b1;
            tick();
            bus.dhit = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int n;
        bus.iREN = 1'b1; bus.dREN = '0; bus.dWEN = '0;
        bus.ihit = 1'b0; bus.dhit = 1'b0; bus.halt = 1'b0;
        RST = 1'b1;
        tick(2);
        check("rst_imemREN", int'(bus.imemREN), 1);
        check("rst_dmemREN", int'(bus.dmemREN), 0);
        check("rst_dmemWEN", int'(bus.dmemWEN), 0);
        check("rst_dgrant", int'(bus.dgrant), 0);
        check("rst_halt_out", int'(bus.halt_out), 0);
        check("rst_pc_wait", int'(bus.pc_wait), 0);
        RST = 1'b0;

        // single read on ch0, dhit in the third grant cycle
        capture(2'b01, 2'b00, 1'b0);
        check("rd_pend_pc_wait", int'(bus.pc_wait), 1);
        check("rd_grant_latency", int'(bus.dgrant), 0);
        tick();
        check("rd_g1_dgrant", int'(bus.dgrant), 1);
        check("rd_g1_dmemREN", int'(bus.dmemREN), 1);
        check("rd_g1_imemREN", int'(bus.imemREN), 0);
        tick();
        check("rd_g2_dgrant", int'(bus.dgrant), 1);
        tick();
        check("rd_g3_dgrant", int'(bus.dgrant), 1);
        bus.dhit = 1'b1;
        tick();
        bus.dhit = 1'b0; bus.dREN = '0;
        check("rd_done_dgrant", int'(bus.dgrant), 0);
        check("rd_done_pc_wait", int'(bus.pc_wait), 0);
        check("rd_done_imemREN", int'(bus.imemREN), 1);

        // round-robin from rr_ptr=0, both channels pending twice
        RST = 1'b1; tick(); RST = 1'b0;
        exp_q.push_back(8'd0); exp_q.push_back(8'd1);
        exp_q.push_back(8'd0); exp_q.push_back(8'd1);
        capture(2'b11, 2'b00, 1'b0);
        serve(1); serve(1);
        capture(2'b11, 2'b00, 1'b0);
        serve(2); serve(1);
        bus.dREN = '0;
        tick();

        // read+write on ch1: write wins
        capture(2'b10, 2'b10, 1'b0);
        wait_grant("rw_wait", ok);
        check("rw_dsel", int'(bus.dsel), 1);
        check("rw_dgrant", int'(bus.dgrant), 2);
        check("rw_dmemWEN", int'(bus.dmemWEN), 1);
        check("rw_dmemREN", int'(bus.dmemREN), 0);
        bus.dhit = 1'b1; tick(); bus.dhit = 1'b0;
        bus.dREN = '0; bus.dWEN = '0;

        // requester withdraws mid-grant -> completes, no timeout
        capture(2'b01, 2'b00, 1'b0);
        wait_grant("drop_wait", ok);
        check("drop_dsel", int'(bus.dsel), 0);
        bus.dREN = '0;
        tick();
        check("drop_dgrant", int'(bus.dgrant), 0);
        check("drop_pc_wait", int'(bus.pc_wait), 0);

        // dhit exactly on the last watchdog cycle: no timeout
        capture(2'b01, 2'b00, 1'b0);
        wait_grant("wd_hit_wait", ok);
        tick(TMO_MAX - 1);
        check("wd_hit_still_granted", int'(bus.dgrant), 1);
        bus.dhit = 1'b1; tick(); bus.dhit = 1'b0;
        check("wd_hit_released", int'(bus.dgrant), 0);
        check("wd_hit_no_tmo", int'(bus.dtimeout), 0);
        bus.dREN = '0;

        // stuck request on ch1: abort after TMO_MAX grant cycles
        capture(2'b10, 2'b00, 1'b0);
        wait_grant("wd_abort_wait", ok);
        tick(TMO_MAX - 1);
        check("wd_cyc200_granted", int'(bus.dgrant), 2);
        check("wd_cyc200_no_tmo", int'(bus.dtimeout), 0);
        tick();
        check("wd_abort_dgrant", int'(bus.dgrant), 0);
        check("wd_abort_dtimeout", int'(bus.dtimeout), 1);
        check("wd_abort_pend_clr", int'(bus.pc_wait), 0);
        tick(3);
        check("wd_tmo_sticky", int'(bus.dtimeout), 1);
        check("wd_no_regrant", int'(bus.dgrant), 0);
        bus.dREN = '0;

        // halt together with two new requests: drain both, then halt
        capture(2'b11, 2'b00, 1'b1);
        check("hlt_imemREN_off", int'(bus.imemREN), 0);
        check("hlt_pc_wait", int'(bus.pc_wait), 1);
        check("hlt_not_yet", int'(bus.halt_out), 0);
        exp_q.push_back(8'd0); exp_q.push_back(8'd1);
        serve(2); serve(1);
        bus.dREN = '0;
        n = 0;
        while (!bus.halt_out && n < 8) begin tick(); n++; end
        check("hlt_halt_out", int'(bus.halt_out), 1);
        check("hlt_imemREN", int'(bus.imemREN), 0);
        check("hlt_dgrant", int'(bus.dgrant), 0);
        tick(5);
        check("hlt_sticky", int'(bus.halt_out), 1);
        check("hlt_sticky_imem", int'(bus.imemREN), 0);

        // reset leaves HALTED; reset mid-grant drops the grant
        RST = 1'b1; tick(); RST = 1'b0;
        check("rst2_halt_out", int'(bus.halt_out), 0);
        check("rst2_imemREN", int'(bus.imemREN), 1);
        check("rst2_dtimeout", int'(bus.dtimeout), 0);
        capture(2'b01, 2'b00, 1'b0);
        wait_grant("rstg_wait", ok);
        RST = 1'b1; tick();
        check("rstg_dgrant", int'(bus.dgrant), 0);
        check("rstg_pc_wait", int'(bus.pc_wait), 0);
        RST = 1'b0; bus.dREN = '0;
        tick(2);
        check("rstg_no_regrant", int'(bus.dgrant), 0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
